// File: rtl/branch_sequencer.sv
// rtl/branch_sequencer.sv - conditional branch T3..T6 step sequencer with condition FF handshake
// Optional per-outcome branch counters are compiled in with BRANCH_STATS_EN.
module branch_sequencer #(
    parameter int IMM_W  = 19,
    parameter int STAT_W = 16
) (
    input  logic              Clock,
    input  logic              Clear,
    input  logic              start,
    input  logic [31:0]       IR,
    input  logic              CON,
    output logic              busy,
    output logic              done,
    output logic [3:0]        C2,
    output logic [31:0]       C_sext,
    output logic              Gra,
    output logic              Rout,
    output logic              CONin,
    output logic              PCout,
    output logic              Yin,
    output logic              Cout,
    output logic              ADD,
    output logic              Zin,
    output logic              Zlowout,
    output logic              PCin,
    output logic              taken
`ifdef BRANCH_STATS_EN
    ,
    output logic [STAT_W-1:0] n_taken,
    output logic [STAT_W-1:0] n_not_taken
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_T3_COND,
        S_T4_PC,
        S_T5_ADD,
        S_T6_LOAD
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  c2_q, c2_d;
    logic [31:0] c_sext_q, c_sext_d;
    logic        taken_q, taken_d;
    logic        accept;
    logic        t6_exit;
    logic [31:0] ir_sext;
    logic        unused_ir;

    assign accept    = (state_q == S_IDLE) && start;
    assign t6_exit   = (state_q == S_T6_LOAD);
    assign ir_sext   = {{(32-IMM_W){IR[IMM_W-1]}}, IR[IMM_W-1:0]};
    assign unused_ir = ^IR[31:23];

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_q  <= S_IDLE;
            c2_q     <= 4'd0;
            c_sext_q <= 32'd0;
            taken_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            c2_q     <= c2_d;
            c_sext_q <= c_sext_d;
            taken_q  <= taken_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        c2_d     = c2_q;
        c_sext_d = c_sext_q;
        taken_d  = taken_q;
        busy     = 1'b0;
        done     = 1'b0;
        Gra      = 1'b0;
        Rout     = 1'b0;
        CONin    = 1'b0;
        PCout    = 1'b0;
        Yin      = 1'b0;
        Cout     = 1'b0;
        ADD      = 1'b0;
        Zin      = 1'b0;
        Zlowout  = 1'b0;
        PCin     = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Fields are captured only here, so IR may change freely mid-sequence.
                if (accept) begin
                    state_d  = S_T3_COND;
                    c2_d     = IR[22:19];
                    c_sext_d = ir_sext;
                end
            end
            S_T3_COND: begin
                busy    = 1'b1;
                Gra     = 1'b1;
                Rout    = 1'b1;
                CONin   = 1'b1;
                state_d = S_T4_PC;
            end
            S_T4_PC: begin
                busy    = 1'b1;
                PCout   = 1'b1;
                Yin     = 1'b1;
                state_d = S_T5_ADD;
            end
            S_T5_ADD: begin
                busy    = 1'b1;
                Cout    = 1'b1;
                ADD     = 1'b1;
                Zin     = 1'b1;
                state_d = S_T6_LOAD;
            end
            S_T6_LOAD: begin
                busy    = 1'b1;
                done    = 1'b1;
                Zlowout = 1'b1;
                // Only strobe that is not Moore: the PC load follows the live CON flag.
                PCin    = CON;
                taken_d = CON;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign C2     = c2_q;
    assign C_sext = c_sext_q;
    assign taken  = taken_q;

`ifdef BRANCH_STATS_EN
    localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

    logic [STAT_W-1:0] n_taken_q, n_taken_d;
    logic [STAT_W-1:0] n_not_taken_q, n_not_taken_d;

    always_comb begin
        n_taken_d     = n_taken_q;
        n_not_taken_d = n_not_taken_q;
        // Counters stick at all-ones rather than wrapping.
        if (t6_exit) begin
            if (CON) begin
                if (~&n_taken_q) n_taken_d = n_taken_q + STAT_ONE;
            end else begin
                if (~&n_not_taken_q) n_not_taken_d = n_not_taken_q + STAT_ONE;
            end
        end
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            n_taken_q     <= '0;
            n_not_taken_q <= '0;
        end else begin
            n_taken_q     <= n_taken_d;
            n_not_taken_q <= n_not_taken_d;
        end
    end

    assign n_taken     = n_taken_q;
    assign n_not_taken = n_not_taken_q;
`else
    logic unused_t6_exit;
    assign unused_t6_exit = t6_exit;
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// tb/tb_branch_sequencer.sv - randomized self-checking bench for branch_sequencer
module tb_branch_sequencer;

    localparam int IMM_W    = 19;
    localparam int STAT_W   = 4;
    localparam int STAT_MAX = (1 << STAT_W) - 1;

    // Strobe order: {Gra, Rout, CONin, PCout, Yin, Cout, ADD, Zin, Zlowout}, indexed by step 0..4
    localparam logic [8:0] STROBE_TAB [5] = '{
        9'b000_000_000,
        9'b111_000_000,
        9'b000_110_000,
        9'b000_001_110,
        9'b000_000_001
    };

    logic        Clock = 1'b0;
    logic        Clear = 1'b0;
    logic        start = 1'b0;
    logic [31:0] IR    = 32'd0;
    logic        CON   = 1'b0;
    logic        busy, done, Gra, Rout, CONin, PCout, Yin, Cout, ADD, Zin, Zlowout, PCin, taken;
    logic [3:0]  C2;
    logic [31:0] C_sext;
`ifdef BRANCH_STATS_EN
    logic [STAT_W-1:0] n_taken, n_not_taken;
`endif

    branch_sequencer #(.IMM_W(IMM_W), .STAT_W(STAT_W)) dut (
        .Clock(Clock), .Clear(Clear), .start(start), .IR(IR), .CON(CON),
        .busy(busy), .done(done), .C2(C2), .C_sext(C_sext),
        .Gra(Gra), .Rout(Rout), .CONin(CONin), .PCout(PCout), .Yin(Yin),
        .Cout(Cout), .ADD(ADD), .Zin(Zin), .Zlowout(Zlowout), .PCin(PCin),
        .taken(taken)
`ifdef BRANCH_STATS_EN
        , .n_taken(n_taken), .n_not_taken(n_not_taken)
`endif
    );

    always #5 Clock = ~Clock;

    int total = 0;
    int bad   = 0;

    // Reference model: step index counts cycles since the accepting edge (0 = idle)
    int          age_m;
    logic [3:0]  c2_m;
    logic [31:0] cs_m;
    logic        taken_m;
    int          nt_m, nn_m;
    int          conin_seen;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sext_ref(input logic [31:0] ir);
        longint v;
        v = longint'(ir & 32'h7FFFF);
        if (v >= 64'sd262144) v = v - 64'sd524288;
        return 32'(v);
    endfunction

    function automatic logic [31:0] mk_ir(input logic [3:0] c2, input logic [18:0] c);
        return {4'b0101, 5'd0, c2, c};
    endfunction

    task automatic model_reset();
        age_m   = 0;
        c2_m    = 4'd0;
        cs_m    = 32'd0;
        taken_m = 1'b0;
        nt_m    = 0;
        nn_m    = 0;
    endtask

    task automatic check_outputs();
        check("strobes", {Gra, Rout, CONin, PCout, Yin, Cout, ADD, Zin, Zlowout}, STROBE_TAB[age_m]);
        check("busy", busy, age_m != 0);
        check("done", done, age_m == 4);
        check("PCin", PCin, (age_m == 4) && CON);
        check("C2", C2, c2_m);
        check("C_sext", C_sext, cs_m);
        check("taken", taken, taken_m);
`ifdef BRANCH_STATS_EN
        check("n_taken", n_taken, nt_m);
        check("n_not_taken", n_not_taken, nn_m);
`endif
    endtask

    task automatic cycle();
        logic        s, c;
        logic [31:0] ir;
        s  = start;
        c  = CON;
        ir = IR;
        @(posedge Clock);
        if (age_m == 4) begin
            taken_m = c;
            if (c) nt_m = (nt_m == STAT_MAX) ? STAT_MAX : nt_m + 1;
            else   nn_m = (nn_m == STAT_MAX) ? STAT_MAX : nn_m + 1;
            age_m = 0;
        end else if (age_m != 0) begin
            age_m = age_m + 1;
        end else if (s) begin
            age_m = 1;
            c2_m  = ir[22:19];
            cs_m  = sext_ref(ir);
        end
        #1;
        if (CONin) conin_seen++;
        check_outputs();
    endtask

    task automatic run_branch(input logic [31:0] ir, input logic con);
        IR    = ir;
        start = 1'b1;
        CON   = con;
        cycle();
        start = 1'b0;
        IR    = $urandom;
        repeat (4) cycle();
    endtask

    initial begin
        int c0;
        model_reset();
        conin_seen = 0;

        #3;
        check_outputs();
        @(negedge Clock);
        Clear = 1'b1;
        cycle();

        // brzr taken
        run_branch(mk_ir(4'b0000, 19'h00010), 1'b1);
        check("brzr_taken", taken, 1'b1);
        check("brzr_C_sext", C_sext, 32'h00000010);

        // brnz not taken
        run_branch(mk_ir(4'b0001, 19'h00010), 1'b0);
        check("brnz_taken", taken, 1'b0);
        check("brnz_C2", C2, 4'b0001);

        // Offset sign extension edges
        run_branch(mk_ir(4'b1110, 19'h7FFFC), 1'b1);
        check("neg_off", C_sext, 32'hFFFFFFFC);
        check("c2_hi_pass", C2, 4'b1110);
        run_branch(mk_ir(4'b0011, 19'h3FFFF), 1'b0);
        check("pos_max_off", C_sext, 32'h0003FFFF);

        // start held 12 cycles with IR churning: three accepts, each latching its own IR
        c0    = conin_seen;
        start = 1'b1;
        repeat (12) begin
            IR  = $urandom;
            CON = 1'($urandom);
            cycle();
        end
        start = 1'b0;
        check("accepts_12", conin_seen - c0, 3);
        repeat (4) cycle();

        // Taken branch, then asynchronous clear in the middle of T4
        run_branch(mk_ir(4'b0010, 19'h00123), 1'b1);
        IR    = mk_ir(4'b0001, 19'h00044);
        start = 1'b1;
        CON   = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        #2;
        Clear = 1'b0;
        #1;
        model_reset();
        check("rst_busy", busy, 1'b0);
        check("rst_strobes", {Gra, Rout, CONin, PCout, Yin, Cout, ADD, Zin, Zlowout, PCin, done}, 11'd0);
        check_outputs();
        @(negedge Clock);
        Clear = 1'b1;
        repeat (3) cycle();
        check("rst_taken_hold", taken, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            start = 1'($urandom_range(0, 1));
            IR    = $urandom;
            CON   = 1'($urandom);
            cycle();
        end
        start = 1'b0;
        repeat (5) cycle();

`ifdef BRANCH_STATS_EN
        Clear = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge Clock);
        Clear = 1'b1;
        for (int i = 0; i < 20; i++) run_branch(mk_ir(4'b0000, 19'($urandom)), 1'b1);
        check("stat_sat_taken", n_taken, 4'hF);
        check("stat_not_taken", n_not_taken, 4'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
